mult_secuencial_qf: RTL and testbench

- Iterative signed fixed-point multiplier, radix-2 shift-add.
- Takes two N-bit Q(N-F).F operands and produces the full 2N-bit signed product.
- Sits directly upstream of the saturating truncation stage, which reduces the 2N-bit product back to N bits.
- Valid/ready handshake on both sides; one multiplication in flight at a time.

---
 rtl/mult_secuencial_qf.sv | 129 ++++++++++++
 tb/tb_mult_secuencial_qf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_secuencial_qf.sv
// Iterative signed fixed-point multiplier, radix-2 shift-add, full 2N-bit product.
// Define MULT_SECUENCIAL_ROUND_EN to add a half-LSB bias at bit F-1 of the result.
module mult_secuencial_qf #(
  parameter int N = 25,
  parameter int F = 14
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] producto,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*N-1:0] mcand_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_q;

  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic [2*N-1:0] acc_nx;
  logic [2*N-1:0] mag;
  logic [2*N-1:0] res;
  logic           accept;
  logic           last;

  if (F < 1 || F >= N) begin : g_bad_f
    $error("F must lie in 1..N-1");
  end

  // Magnitudes fit N unsigned bits, including the most negative value.
  assign abs_a  = op_a[N-1] ? (~op_a) + N'(1) : op_a;
  assign abs_b  = op_b[N-1] ? (~op_b) + N'(1) : op_b;
  assign accept = in_valid && (state_q == IDLE);
  assign last   = (cnt_q == CW'(N - 1));
  assign acc_nx = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mag    = sign_q ? (~acc_q) + (2*N)'(1) : acc_q;

`ifdef MULT_SECUENCIAL_ROUND_EN
  localparam logic [2*N-1:0] RND = (2*N)'(1) << (F - 1);
  assign res = mag + RND;
`else
  assign res = mag;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last) state_d = SIGN;
      end
      SIGN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add datapath and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      producto <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q  <= {{N{1'b0}}, abs_a};
            mplier_q <= abs_b;
            sign_q   <= op_a[N-1] ^ op_b[N-1];
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        SIGN: begin
          producto <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_secuencial_qf.sv
// Scoreboard bench for mult_secuencial_qf: random and directed operand pairs.
// Reference product comes from plain 64-bit integer multiplication.
module tb_mult_secuencial_qf;

  localparam int N = 25;
  localparam int F = 14;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   op_a = '0;
  logic [N-1:0]   op_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] producto;
  logic           busy;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [2*N-1:0] exp_q[$];
  int             lat_q[$];
  logic           prev_ov = 1'b0;

  mult_secuencial_qf #(.N(N), .F(F)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .producto  (producto),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*N-1:0] model(
    input logic signed [N-1:0] a,
    input logic signed [N-1:0] b
  );
    longint p;
    p = longint'(a) * longint'(b);
`ifdef MULT_SECUENCIAL_ROUND_EN
    p = p + (64'sd1 <<< (F - 1));
`endif
    return p[2*N-1:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: latency on out_valid rise, product on handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ov <= 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("latency", cyc - lat_q.pop_front(), N + 2);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("producto", $signed(producto), $signed(exp_q.pop_front()));
        end
      end
      prev_ov <= out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic start(input logic [N-1:0] a, input logic [N-1:0] b);
    wait_ready();
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    lat_q.push_back(cyc);
    tick();
    in_valid = 1'b0;
    op_a     = N'($urandom);
    op_b     = N'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    int t = 0;
    logic [2*N-1:0] p;
    out_ready = (hold == 0);
    start(a, b);
    while (!out_valid && t < 60) begin
      in_valid = 1'($urandom);
      tick();
      t++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    if (hold > 0) begin
      p = producto;
      repeat (hold) begin
        in_valid = 1'($urandom);
        op_a     = N'($urandom);
        tick();
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_producto", $signed(producto), $signed(p));
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      chk("no_accept_on_handshake", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      tick();
    end
    chk("out_valid_pulse", out_valid, 0);
    chk("in_ready_return", in_ready, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_producto", producto, 0);
    reset_n = 1'b1;
    tick();

    run(N'(16384), N'(16384), 0);
    run(N'(-24576), N'(32768), 0);
    run(N'(0), N'(-1), 0);
    run(N'(-(2**24)), N'(-(2**24)), 0);
    run(N'(-(2**24)), N'(2**24 - 1), 0);
    run(N'(1), N'(1), 0);
    run(N'(-1), N'(1), 0);
    run(N'(12345), N'(-678), 10);

    // Abort in the middle of CALC.
    out_ready = 1'b1;
    start(N'(16384), N'(16384));
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    chk("abort_out_valid", out_valid, 0);
    chk("abort_producto", producto, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run(N'(-24576), N'(32768), 0);

    for (int i = 0; i < 20; i++) begin
      run(N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
    end

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
